// File: rtl/sim_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sim_run_ctrl
// Brief    : Cycle-accurate run controller: core reset sequencing, cycle
//            counting, tohost exit detection, pass/fail/timeout flags.
//            Optional retire counter enabled by SIM_RUN_CTRL_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sim_run_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CNT_WIDTH   = 32,
  parameter int                    RST_CYCLES  = 4,
  parameter int unsigned           MAX_CYCLES  = 1000,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(32'h0000_0FF0)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
  input  logic                  retire,
`endif
  output logic                  core_rst_n,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] exit_code,
  output logic [CNT_WIDTH-1:0]  cycle_count
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic                  cpi_ready
`endif
);

  localparam int                   c_RCNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_RCNT_W-1:0]  c_RCNT_INIT  = c_RCNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RESET = 2'd1;
  localparam logic [1:0] c_ST_RUN   = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [c_RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [DATA_WIDTH-1:0] exit_code_q, exit_code_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;

  logic w_launch;
  logic w_tohost_hit;
  logic w_timeout_hit;

  assign w_launch      = start && ((state_q == c_ST_IDLE) || (state_q == c_ST_DONE));
  assign w_tohost_hit  = (state_q == c_ST_RUN) && mem_we && (mem_addr == TOHOST_ADDR);
  assign w_timeout_hit = (state_q == c_ST_RUN) && (cycle_count_q == c_LAST_CYCLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (start) state_d = c_ST_RESET;
      c_ST_RESET: if (rcnt_q == '0) state_d = c_ST_RUN;
      c_ST_RUN:   if (w_tohost_hit || w_timeout_hit) state_d = c_ST_DONE;
      c_ST_DONE:  if (start) state_d = c_ST_RESET;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Output / datapath next values; an exit store outranks a same-cycle timeout
  always_comb begin
    rcnt_d        = rcnt_q;
    cycle_count_d = cycle_count_q;
    exit_code_d   = exit_code_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    if (w_launch) begin
      rcnt_d        = c_RCNT_INIT;
      cycle_count_d = '0;
      exit_code_d   = '0;
      pass_d        = 1'b0;
      timeout_d     = 1'b0;
    end else if (state_q == c_ST_RESET) begin
      if (rcnt_q != '0) rcnt_d = rcnt_q - 1'b1;
    end else if (state_q == c_ST_RUN) begin
      cycle_count_d = cycle_count_q + 1'b1;
      if (w_tohost_hit) begin
        exit_code_d = mem_wdata;
        pass_d      = (mem_wdata == DATA_WIDTH'(1));
      end else if (w_timeout_hit) begin
        timeout_d   = 1'b1;
      end
    end
    core_rst_n_d = (state_d == c_ST_RUN);
    running_d    = (state_d == c_ST_RUN);
    done_d       = (state_d == c_ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q        <= '0;
      cycle_count_q <= '0;
      exit_code_q   <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      core_rst_n_q  <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      rcnt_q        <= rcnt_d;
      cycle_count_q <= cycle_count_d;
      exit_code_q   <= exit_code_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      core_rst_n_q  <= core_rst_n_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;

`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 cpi_ready_q, cpi_ready_d;

  always_comb begin
    instret_d = instret_q;
    if (w_launch) begin
      instret_d = '0;
    end else if ((state_q == c_ST_RUN) && retire) begin
      instret_d = instret_q + 1'b1;
    end
    cpi_ready_d = (state_d == c_ST_DONE) && (instret_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q   <= '0;
      cpi_ready_q <= 1'b0;
    end else begin
      instret_q   <= instret_d;
      cpi_ready_q <= cpi_ready_d;
    end
  end

  assign instret   = instret_q;
  assign cpi_ready = cpi_ready_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_run_ctrl
// Brief    : Self-checking bench for sim_run_ctrl (RST_CYCLES=4, MAX_CYCLES=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_run_ctrl;

  localparam int c_RST_CYCLES = 4;
  localparam int c_MAX_CYCLES = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        running;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;
  logic        retire;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
  logic [31:0] instret;
  logic        cpi_ready;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sim_run_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (32),
    .RST_CYCLES (c_RST_CYCLES),
    .MAX_CYCLES (c_MAX_CYCLES),
    .TOHOST_ADDR(32'h0000_0FF0)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
    .retire     (retire),
`endif
    .core_rst_n (core_rst_n),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .exit_code  (exit_code),
    .cycle_count(cycle_count)
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
    ,
    .instret    (instret),
    .cpi_ready  (cpi_ready)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          store_cyc;
    logic [31:0] wdata;
    int          stray_cyc;
    logic        stray_we;
    logic [31:0] stray_addr;
    int          ret_n;
    logic        exp_pass;
    logic        exp_to;
    logic [31:0] exp_exit;
    int          exp_cnt;
  } scen_t;

  scen_t tab [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_done_state(input scen_t s);
    check("done",        64'(done),        64'(1));
    check("running_dn",  64'(running),     64'(0));
    check("core_rst_dn", 64'(core_rst_n),  64'(0));
    check("pass",        64'(pass),        64'(s.exp_pass));
    check("timeout",     64'(timeout),     64'(s.exp_to));
    check("exit_code",   64'(exit_code),   64'(s.exp_exit));
    check("cycle_count", 64'(cycle_count), 64'(s.exp_cnt));
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
    check("instret",     64'(instret),     64'(s.ret_n));
    check("cpi_ready",   64'(cpi_ready),   64'(s.ret_n != 0));
`endif
  endtask

  task automatic run_scen(input scen_t s);
    int n;
    int c;
    start = 1'b1;
    step();
    start = 1'b0;
    check("launch_core_rst", 64'(core_rst_n),  64'(0));
    check("launch_count",    64'(cycle_count), 64'(0));
    check("launch_exit",     64'(exit_code),   64'(0));
    check("launch_flags",    64'({done, pass, timeout}), 64'(0));
    // Retire pulses during the reset phase must not count
    n = 0;
    while (!running && n < 20) begin
      check("rst_phase_low", 64'(core_rst_n), 64'(0));
      retire = (n < 2);
      step();
      n++;
    end
    retire = 1'b0;
    check("rst_len",     64'(n),          64'(c_RST_CYCLES));
    check("core_rst_hi", 64'(core_rst_n), 64'(1));
    c = 0;
    while (!done && c < 200) begin
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (c == s.store_cyc) begin
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0FF0;
        mem_wdata = s.wdata;
      end else if (c == s.stray_cyc) begin
        mem_we    = s.stray_we;
        mem_addr  = s.stray_addr;
        mem_wdata = 32'h1;
      end
      retire = (c < s.ret_n);
      step();
      c++;
    end
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    retire    = 1'b0;
    check("run_len", 64'(c), 64'(s.exp_cnt));
    check_done_state(s);
    repeat (3) step();
    check_done_state(s);
  endtask

  initial begin
    int n;
    tab[0] = '{20, 32'h1,        -1, 1'b0, 32'h0,         7, 1'b1, 1'b0, 32'h1,        21};
    tab[1] = '{30, 32'h5,        10, 1'b1, 32'h0000_0FF4, 0, 1'b0, 1'b0, 32'h5,        31};
    tab[2] = '{-1, 32'h0,        12, 1'b0, 32'h0000_0FF0, 3, 1'b0, 1'b1, 32'h0,        50};
    tab[3] = '{49, 32'h1,        -1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 32'h1,        50};
    tab[4] = '{0,  32'hFFFF_FFFF, -1, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1};
    tab[5] = '{48, 32'h1,        47, 1'b1, 32'h8000_0FF0, 2, 1'b1, 1'b0, 32'h1,        49};

    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; retire = 1'b0;
    step();
    step();
    check("rst_core_rst_n", 64'(core_rst_n),  64'(0));
    check("rst_flags",      64'({running, done, pass, timeout}), 64'(0));
    check("rst_exit",       64'(exit_code),   64'(0));
    check("rst_count",      64'(cycle_count), 64'(0));
    rst = 1'b0;
    repeat (3) step();
    check("idle_hold", 64'({core_rst_n, running, done}), 64'(0));

    for (int i = 0; i < 6; i++) begin
      run_scen(tab[i]);
    end

    // rst in DONE clears captured results
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_done_flags", 64'({running, done, pass, timeout}), 64'(0));
    check("rst_done_exit",  64'(exit_code),   64'(0));
    check("rst_done_count", 64'(cycle_count), 64'(0));

    // start is ignored in RUN; rst mid-run wins over a simultaneous start
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!running && n < 20) begin
      step();
      n++;
    end
    check("rerun_running", 64'(running), 64'(1));
    repeat (5) step();
    check("run_count5", 64'(cycle_count), 64'(5));
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_run", 64'({running, cycle_count}), 64'({1'b1, 32'd6}));
    repeat (3) step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check("midrun_rst",       64'({core_rst_n, running, done, pass, timeout}), 64'(0));
    check("midrun_rst_count", 64'(cycle_count), 64'(0));
    repeat (2) step();
    check("post_rst_idle", 64'({core_rst_n, running, done}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
